// File: rtl/main_memory_responder.sv
// Main-memory responder for the L2 <-> MM block-transfer interface.
// Serves block reads (line fills) and block writes (writebacks) of block_size
// words, one word per clock, from a 2**addr_width-word array. Reads start
// after a programmable latency.
// Optional build macro MM_STATS_EN adds the MM_statistics burst counters.
module main_memory_responder #(
    parameter int n            = 32,
    parameter int block_size   = 16,
    parameter int addr_width   = 15,
    parameter int read_latency = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [addr_width-1:0]         MM_word_address,
    input  logic                          MM_read_request,
    input  logic                          MM_write_request,
    input  logic [n-1:0]                  MM_write_word,
    output logic [n-1:0]                  MM_read_word,
    output logic                          MM_read_valid,
    output logic                          MM_write_ready,
    output logic [$clog2(block_size)-1:0] MM_offset,
    output logic                          MM_busy,
    output logic                          MM_done
`ifdef MM_STATS_EN
    ,
    output logic [31:0]                   MM_statistics
`endif
);

    localparam int OFF_W = $clog2(block_size);
    localparam int BLK_W = addr_width - OFF_W;
    localparam int LAT_W = (read_latency > 1) ? $clog2(read_latency) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((read_latency > 0) ? read_latency - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [BLK_W-1:0] blk;         // block number of the accepted request
    logic [OFF_W-1:0] offset;      // word offset within the burst
    logic [LAT_W-1:0] lat_cnt;     // cycles already spent in RD_WAIT
    logic [n-1:0]     mem [2**addr_width];
    logic [addr_width-1:0] rd_addr;
    logic             accept_wr;
    logic             accept_rd;
    logic             last_word;
    logic             addr_low_unused;

    // Writes win over reads when both arrive together (writeback before fill).
    assign accept_wr = (state == IDLE) && MM_write_request;
    assign accept_rd = (state == IDLE) && MM_read_request && !MM_write_request;
    assign last_word = &offset;

    // The in-block address bits are dropped: bursts always start at offset 0.
    assign addr_low_unused = ^MM_word_address[OFF_W-1:0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_wr) begin
                    next_state = WR_BURST;
                end else if (accept_rd) begin
                    next_state = (read_latency == 0) ? RD_BURST : RD_WAIT;
                end
            end
            RD_WAIT:  if (lat_cnt == LAT_LAST) next_state = RD_BURST;
            RD_BURST: if (last_word) next_state = DONE;
            WR_BURST: if (last_word) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        MM_read_valid  = (state == RD_BURST);
        MM_write_ready = (state == WR_BURST);
        MM_offset      = (MM_read_valid || MM_write_ready) ? offset : '0;
        MM_busy        = (state == RD_WAIT) || (state == RD_BURST) || (state == WR_BURST);
        MM_done        = (state == DONE);
    end

    // Address of the word that will be presented after the next edge.
    always_comb begin
        rd_addr = {blk, offset + 1'b1};
        if (state == IDLE) begin
            rd_addr = {MM_word_address[addr_width-1:OFF_W], {OFF_W{1'b0}}};
        end else if (state == RD_WAIT) begin
            rd_addr = {blk, {OFF_W{1'b0}}};
        end
    end

    // Burst bookkeeping and the registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk          <= '0;
            offset       <= '0;
            lat_cnt      <= '0;
            MM_read_word <= '0;
        end else begin
            if (accept_wr || accept_rd) begin
                blk    <= MM_word_address[addr_width-1:OFF_W];
                offset <= '0;
            end else if ((state == RD_BURST) || (state == WR_BURST)) begin
                offset <= offset + 1'b1;
            end
            lat_cnt <= ((state == RD_WAIT) && (next_state == RD_WAIT)) ? lat_cnt + 1'b1 : '0;
            // Loading one edge early makes word k visible while MM_offset = k.
            if (next_state == RD_BURST) begin
                MM_read_word <= mem[rd_addr];
            end
        end
    end

    // Array write port, one word per WR_BURST edge.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; contents survive reset
        // and a reset-free array maps onto block RAM.
        if (state == WR_BURST) begin
            mem[{blk, offset}] <= MM_write_word;
        end
    end

`ifdef MM_STATS_EN
    logic        last_was_read;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // Saturating completed-burst counters, bumped in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_was_read <= 1'b0;
            rd_count      <= '0;
            wr_count      <= '0;
        end else begin
            if (accept_wr) begin
                last_was_read <= 1'b0;
            end else if (accept_rd) begin
                last_was_read <= 1'b1;
            end
            if (state == DONE) begin
                if (last_was_read) begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end else begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    assign MM_statistics = {rd_count, wr_count};
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances share all inputs, one with
// read_latency = 4 and one with read_latency = 0. Expected cycle-by-cycle
// outputs come from a transaction-level model (cycle index since acceptance).
module tb_main_memory_responder;

    localparam int N  = 32;
    localparam int BS = 16;
    localparam int AW = 15;

    typedef logic [N-1:0] blk_t [BS];

    typedef struct {
        bit is_wr;
        int addr;
        int mult;
        int add;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [N-1:0]  wr_word = '0;

    logic [N-1:0]  rw   [2];
    logic          rv   [2];
    logic          wrdy [2];
    logic [3:0]    off  [2];
    logic          busy [2];
    logic          done [2];
`ifdef MM_STATS_EN
    logic [31:0]   stats [2];
    int            n_rd = 0;
    int            n_wr = 0;
`endif

    int            n_pass = 0;
    int            n_total = 0;
    logic [N-1:0]  ref_mem [2**AW];
    logic [N-1:0]  last_w [2] = '{default: '0};
    int            lat [2] = '{4, 0};
    int            written [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        main_memory_responder #(
            .n(N), .block_size(BS), .addr_width(AW), .read_latency((g == 0) ? 4 : 0)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .MM_word_address(addr),
            .MM_read_request(rd_req),
            .MM_write_request(wr_req),
            .MM_write_word(wr_word),
            .MM_read_word(rw[g]),
            .MM_read_valid(rv[g]),
            .MM_write_ready(wrdy[g]),
            .MM_offset(off[g]),
            .MM_busy(busy[g]),
            .MM_done(done[g])
`ifdef MM_STATS_EN
            ,
            .MM_statistics(stats[g])
`endif
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both instances idle, read word holding its last value.
    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s dut%0d busy", tag, d), busy[d], 0);
            check($sformatf("%s dut%0d valid", tag, d), rv[d], 0);
            check($sformatf("%s dut%0d ready", tag, d), wrdy[d], 0);
            check($sformatf("%s dut%0d offset", tag, d), off[d], 0);
            check($sformatf("%s dut%0d done", tag, d), done[d], 0);
            check($sformatf("%s dut%0d word", tag, d), rw[d], last_w[d]);
        end
    endtask

    // Read transfer, cycle c after the acceptance edge.
    task automatic chk_rd(input int d, input int c, input blk_t exp);
        int  l = lat[d];
        bit  in_b = (c >= l) && (c < l + BS);
        if (in_b) last_w[d] = exp[c - l];
        check($sformatf("rd dut%0d c%0d valid", d, c), rv[d], in_b);
        check($sformatf("rd dut%0d c%0d offset", d, c), off[d], in_b ? c - l : 0);
        check($sformatf("rd dut%0d c%0d word", d, c), rw[d], last_w[d]);
        check($sformatf("rd dut%0d c%0d busy", d, c), busy[d], c < l + BS);
        check($sformatf("rd dut%0d c%0d done", d, c), done[d], c == l + BS);
        check($sformatf("rd dut%0d c%0d ready", d, c), wrdy[d], 0);
    endtask

    task automatic check_read(input blk_t exp, input int last_c);
        for (int c = 0; c <= last_c; c++) begin
            for (int d = 0; d < 2; d++) chk_rd(d, c, exp);
            if (c < last_c) step();
        end
    endtask

    task automatic run_read(input int a, input blk_t exp);
        addr   = AW'(a);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check_read(exp, lat[0] + BS);
        step();
`ifdef MM_STATS_EN
        n_rd++;
`endif
        chk_idle("after rd");
    endtask

    task automatic run_write(input int a, input blk_t dat, input bit keep_read);
        int base = a & ~(BS - 1);
        addr   = AW'(a);
        wr_req = 1'b1;
        rd_req = keep_read;
        step();
        wr_req = 1'b0;
        for (int c = 0; c <= BS; c++) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("wr dut%0d c%0d ready", d, c), wrdy[d], c < BS);
                check($sformatf("wr dut%0d c%0d offset", d, c), off[d], (c < BS) ? c : 0);
                check($sformatf("wr dut%0d c%0d busy", d, c), busy[d], c < BS);
                check($sformatf("wr dut%0d c%0d done", d, c), done[d], c == BS);
                check($sformatf("wr dut%0d c%0d valid", d, c), rv[d], 0);
            end
            if (c < BS) begin
                wr_word = dat[c];
                ref_mem[base + c] = dat[c];
            end
            step();
        end
`ifdef MM_STATS_EN
        n_wr++;
`endif
        written.push_back(base);
    endtask

    task automatic ref_blk(input int a, output blk_t b);
        int base = a & ~(BS - 1);
        for (int k = 0; k < BS; k++) b[k] = ref_mem[base + k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        blk_t d;
        blk_t e;

        tbl[0] = '{1'b1, 1000,  5, 0};
        tbl[1] = '{1'b0, 1003,  5, 0};
        tbl[2] = '{1'b1, 32767, 3, 100};
        tbl[3] = '{1'b0, 32760, 3, 100};
        tbl[4] = '{1'b1, 17,    7, 1};
        tbl[5] = '{1'b0, 31,    7, 1};
        tbl[6] = '{1'b0, 992,   5, 0};

        // Reset state.
        #2 reset = 1'b1;
        #1 chk_idle("reset");
        step();
        step();
        reset = 1'b0;
        chk_idle("post reset");

        // Table-driven transfers; read expectations come from the table.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < BS; k++) d[k] = N'(tbl[i].mult * k + tbl[i].add);
            if (tbl[i].is_wr) begin
                run_write(tbl[i].addr, d, 1'b0);
                chk_idle($sformatf("tbl%0d", i));
            end else begin
                run_read(tbl[i].addr, d);
            end
        end

        // Both requests together: write first, read follows after DONE.
        for (int k = 0; k < BS; k++) d[k] = 32'h0000_A000 + N'(k);
        run_write(0, d, 1'b1);
        chk_idle("simul gap");
        step();
        rd_req = 1'b0;
        check_read(d, lat[0] + BS);
        step();
`ifdef MM_STATS_EN
        n_rd++;
`endif
        chk_idle("simul end");

        // Reset at read-burst offset 7 of the latency-4 instance.
        for (int k = 0; k < BS; k++) d[k] = N'(5 * k);
        addr   = AW'(1000);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check_read(d, lat[0] + 7);
        reset = 1'b1;
        last_w = '{default: '0};
`ifdef MM_STATS_EN
        n_rd = 0;
        n_wr = 0;
`endif
        #1 chk_idle("async reset");
        step();
        reset = 1'b0;
        chk_idle("after abort");
        run_read(1000, d);

        // Random blocks checked against the reference array.
        for (int i = 0; i < 6; i++) begin
            int a = int'($urandom_range(0, 2**AW - 1));
            for (int k = 0; k < BS; k++) d[k] = $urandom;
            run_write(a, d, 1'b0);
            ref_blk(a, e);
            run_read((a & ~(BS - 1)) | int'($urandom_range(0, BS - 1)), e);
            a = written[$urandom_range(0, written.size() - 1)];
            ref_blk(a, e);
            run_read(a, e);
        end

`ifdef MM_STATS_EN
        for (int g = 0; g < 2; g++)
            check($sformatf("stats dut%0d", g), stats[g], {n_rd[15:0], n_wr[15:0]});
        reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++)
            check($sformatf("stats reset dut%0d", g), stats[g], 0);
        step();
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Main-memory side of the L2↔MM block-transfer interface; responds to L2 read (line fill) and write (writeback) requests.
- Holds a 2**addr_width-word array.
- Serves whole blocks of block_size words, one word per clock, after a programmable read latency.
- Used as the MM model under the L2 cache in the two-core system and in L2-level benches.

Parameters:
- n, 32, data word width
- block_size, 16, words per burst (power of 2, ≥2)
- addr_width, 15, word-address width; array depth = 2**addr_width
- read_latency, 4, wait cycles between read acceptance and first read word (0 allowed)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- MM_word_address  input  addr_width  word address from L2; sampled only at acceptance
- MM_read_request  input  1  block read request from L2
- MM_write_request  input  1  block write request from L2
- MM_write_word  input  n  write data from L2, one word per WR_BURST cycle
- MM_read_word  output  n  read data to L2
- MM_read_valid  output  1  MM_read_word holds burst word MM_offset
- MM_write_ready  output  1  MM_write_word is captured at this clock edge for word MM_offset
- MM_offset  output  log2(block_size)  current word offset within the burst
- MM_busy  output  1  request accepted and not yet finished
- MM_done  output  1  one-cycle pulse at transfer end

Behaviour:
- Reset (async, active-high): FSM→IDLE; all outputs 0; latency and offset counters 0. Array contents are not cleared. A reset mid-burst aborts the burst; words already written stay written.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, DONE.
- IDLE: a request is accepted at the clock edge where it is high.
  - Write has priority when both requests are high (writeback before fill).
  - On acceptance: base = MM_word_address with the low log2(block_size) bits zeroed; offset = 0; MM_busy = 1 from the next cycle.
  - Read goes to RD_WAIT, or directly to RD_BURST when read_latency = 0. Write goes to WR_BURST.
- RD_WAIT: counts read_latency cycles, then enters RD_BURST. MM_read_valid = 0.
- RD_BURST: lasts block_size cycles. MM_read_valid = 1 and MM_read_word = mem[base+MM_offset]; offset increments each edge. After offset block_size-1, go to DONE.
- WR_BURST: lasts block_size cycles with MM_write_ready = 1. On each edge, mem[base+MM_offset] <= MM_write_word and offset increments. After offset block_size-1, go to DONE.
- DONE: one cycle with MM_done = 1 and MM_busy = 0, then IDLE. Requests are not accepted in DONE. Requests still high in IDLE on the following edge start a new transfer.
- Request inputs are ignored outside IDLE; deasserting a request mid-transfer does not abort the burst.
- Outside their states, MM_read_valid, MM_write_ready and MM_offset are 0; MM_read_word holds its last value.
- Address arithmetic: base+offset never crosses the block, so there is no wrap beyond the array.
- Total read time: 1 acceptance edge + read_latency + block_size + 1 (DONE) cycles. Total write time: 1 + block_size + 1 cycles.

Optional Feature:
- Macro MM_STATS_EN.
- Defined:
  - Adds output MM_statistics [31:0]: upper 16 bits = completed read bursts, lower 16 bits = completed write bursts.
  - Each field increments in DONE and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port and no counters; behaviour otherwise identical.

Test Plan:
- Write burst at address 1000 (base 992), MM_write_word = 5*k on offset k → MM_write_ready high 16 cycles, MM_done pulse, mem[992+k] = 5k.
- Read burst at 1003 after the above, read_latency = 4 → MM_read_valid low 4 cycles after acceptance, then 16 cycles returning 0,5,...,75 with MM_offset 0..15; MM_done 1 cycle later.
- MM_read_request and MM_write_request high together at address 0 → write burst served first; read burst follows after DONE; read returns the just-written data.
- Reset asserted at read-burst offset 7 → outputs 0 immediately (asynchronously), state IDLE; a new read of the same block returns the full correct block.
- read_latency = 0, read at 32767 → first valid word in the cycle after acceptance, base 32752, 16 words, no out-of-range access.
- MM_STATS_EN defined, 2 reads + 3 writes → MM_statistics = 32'h0002_0003; after reset 0.
